// File: rtl/serializer_64.sv
// serializer_64: accepts a wide word over valid/ready and emits it MSB byte first
// as a byte stream over a second valid/ready handshake, with gap-free back-to-back words.
module serializer_64 #(
  parameter int BYTE_W    = 8,
  parameter int NUM_BYTES = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BYTE_W*NUM_BYTES-1:0] din,
  input  logic                        din_valid,
  output logic                        din_ready,
  output logic [BYTE_W-1:0]           dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic                        dout_last,
  output logic                        busy
);
  localparam int W  = BYTE_W * NUM_BYTES;
  localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);

  logic [0:0]    state;
  logic [W-1:0]  sr;
  logic [CW-1:0] cnt;
  logic          take;
  logic          give;

  always_comb begin
    dout       = sr[W-1 -: BYTE_W];
    dout_valid = state == SEND;
    busy       = state == SEND;
    dout_last  = (state == SEND) && (cnt == LAST);
    din_ready  = (state == IDLE) || (dout_last && dout_ready);
    take       = din_valid && din_ready;
    give       = dout_valid && dout_ready;
  end

  // shifting on the final byte too leaves sr all-zero, so dout reads 0 while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else if (take) begin
      state <= SEND;
      sr    <= din;
      cnt   <= '0;
    end else if (give) begin
      sr    <= sr << BYTE_W;
      cnt   <= dout_last ? '0 : cnt + 1'b1;
      state <= dout_last ? IDLE : SEND;
    end
  end
endmodule

// File: tb/tb_serializer_64.sv
// tb_serializer_64: directed vectors for serializer_64 covering reset, single and
// back-to-back words, backpressure, mid-word reset and byte-packing round trip.
module tb_serializer_64;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;
  logic        busy;
  int          nvec = 0;
  int          nerr = 0;
  logic [63:0] pack;

  serializer_64 dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_at(input logic [63:0] w, input int k);
    return w[63-8*k -: 8];
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, 64'(dout_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_last"}, 64'(dout_last), 64'd0);
    chk({tag, "_rdy"}, 64'(din_ready), 64'd1);
    chk({tag, "_dout"}, 64'(dout), 64'd0);
  endtask

  // offer a word from IDLE, then drain it with a cyclic dout_ready pattern
  task automatic send_word(input string tag, input logic [63:0] w, input logic [15:0] pat);
    int k = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [7:0] prev = '0;
    din = w;
    din_valid = 1'b1;
    dout_ready = 1'b0;
    #1;
    chk({tag, "_accept"}, 64'(din_ready), 64'd1);
    step();
    din_valid = 1'b0;
    din = ~w;
    pack = '0;
    while (k < 8 && cyc < 64) begin
      dout_ready = pat[cyc % 16];
      #1;
      chk({tag, "_valid"}, 64'(dout_valid), 64'd1);
      chk({tag, "_byte"}, 64'(dout), 64'(byte_at(w, k)));
      chk({tag, "_last"}, 64'(dout_last), 64'(k == 7));
      chk({tag, "_dinrdy"}, 64'(din_ready), 64'(k == 7 && dout_ready));
      if (stalled) chk({tag, "_hold"}, 64'(dout), 64'(prev));
      stalled = !dout_ready;
      prev = dout;
      if (dout_ready) begin
        pack = {pack[55:0], dout};
        k++;
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    chk({tag, "_count"}, 64'(k), 64'd8);
    if (pat == 16'hFFFF) chk({tag, "_cycles"}, 64'(cyc), 64'd8);
    chk({tag, "_pack"}, pack, w);
    dout_ready = 1'b0;
    #1;
    check_idle({tag, "_end"});
  endtask

  initial begin
    logic [63:0] w1;
    logic [63:0] w2;
    rst = 1'b0;
    din = 64'hDEAD_BEEF_DEAD_BEEF;
    din_valid = 1'b0;
    dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b1;
    repeat (3) step();
    check_idle("post_reset");

    send_word("single", 64'h0123_4567_89AB_CDEF, 16'hFFFF);

    w1 = 64'h1111_1111_1111_1111;
    w2 = 64'hFEDC_BA98_7654_3210;
    din = w1;
    din_valid = 1'b1;
    dout_ready = 1'b1;
    #1;
    chk("b2b_accept0", 64'(din_ready), 64'd1);
    step();
    din = w2;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) din_valid = 1'b0;
      #1;
      chk("b2b_valid", 64'(dout_valid), 64'd1);
      chk("b2b_byte", 64'(dout), 64'(byte_at(i < 8 ? w1 : w2, i % 8)));
      chk("b2b_last", 64'(dout_last), 64'(i % 8 == 7));
      chk("b2b_dinrdy", 64'(din_ready), 64'(i == 7 || i == 15));
      step();
    end
    dout_ready = 1'b0;
    #1;
    check_idle("b2b_end");

    send_word("bp", 64'hA5A5_5A5A_0F0F_F0F0, 16'b1011_0100_1101_1001);

    din = 64'h0102_0304_0506_0708;
    din_valid = 1'b1;
    dout_ready = 1'b1;
    step();
    din_valid = 1'b0;
    repeat (3) step();
    chk("mid_byte3", 64'(dout), 64'h04);
    dout_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_idle("mid_reset");
    step();
    rst = 1'b1;
    step();
    check_idle("mid_release");

    send_word("after_rst", 64'hCAFE_0000_0000_BEEF, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/serializer_64.md
# serializer_64

Serializer for the 8-byte sample-word path: accepts one 64-bit word over a valid/ready handshake and emits it as eight consecutive 8-bit bytes over a second valid/ready handshake.
- Byte order is most-significant byte first, so the byte-wise shift-in delay/packing line (newest byte into bits [7:0]) rebuilds the original word.
- Sits on the transmit side of that line: word-level producers feed `serializer_64`, and its byte stream drives the byte-wide datapath.

## Interface
- BYTE_W, 8, width of one output byte in bits
- NUM_BYTES, 8, bytes per input word; input word width is BYTE_W*NUM_BYTES (64 by default)
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset (low = reset asserted)
- din  input  BYTE_W*NUM_BYTES  word to serialize
- din_valid  input  1  din holds a valid word
- din_ready  output  1  block can accept a word this cycle
- dout  output  BYTE_W  current output byte
- dout_valid  output  1  dout holds a valid byte
- dout_ready  input  1  downstream accepts dout this cycle
- dout_last  output  1  dout is the final (least-significant) byte of the word
- busy  output  1  a word is held and not yet fully emitted

## Operation
- Word transfer occurs on a rising edge where din_valid && din_ready.
- Byte transfer occurs on a rising edge where dout_valid && dout_ready.
- State: IDLE (no word held) and SEND (word held).
- Internal registers:
  - shift register `sr` of BYTE_W*NUM_BYTES bits;
  - byte counter `cnt` of $clog2(NUM_BYTES) bits, range 0..NUM_BYTES-1.
- Outputs:
  - dout = sr[top BYTE_W bits]; dout_valid = busy = (state == SEND); dout_last = (state == SEND) && (cnt == NUM_BYTES-1).
  - din_ready = (state == IDLE) || (dout_last && dout_ready). The second term gives gap-free back-to-back words.
- IDLE:
  - On word transfer: sr <= din, cnt <= 0, go to SEND.
  - With din_valid low: stay in IDLE.
- SEND, on byte transfer with cnt < NUM_BYTES-1: sr <= sr << BYTE_W (zero fill), cnt <= cnt+1.
- SEND, on byte transfer with cnt == NUM_BYTES-1:
  - If a word transfer occurs in the same edge: sr <= din, cnt <= 0, stay in SEND.
  - Otherwise: go to IDLE, cnt <= 0.
- SEND with dout_ready low: sr, cnt and all outputs hold. dout must not change while dout_valid is high and dout_ready is low.
- din is sampled only on a word transfer edge. din changes at other times have no effect.
- Reset (rst low, any time, including mid-word):
  - state = IDLE, sr = 0, cnt = 0; the partially sent word is discarded.
  - Output values during reset: dout = 0, dout_valid = 0, dout_last = 0, busy = 0, din_ready = 1.
  - First word accepted on the first rising edge after rst returns high with din_valid high.

## Timing
- Latency: word accepted at edge k → byte 0 (din[63:56]) valid in the cycle after edge k, with dout_valid high.
- Throughput with dout_ready held high: one byte per cycle, a word every NUM_BYTES cycles, and no idle cycle between words when din_valid is high at each last-byte edge.
- din_ready depends combinationally on dout_ready in SEND. All other outputs are registered-state decodes.
- No combinational path from din or din_valid to any output.
- dout_last is high for exactly one accepted byte per word.

## Test plan
- Reset state:
  - Stimulus: rst low with clk running, then released.
  - Required response: dout_valid = 0, din_ready = 1, dout = 0 during reset; nothing emitted until a word is offered.
- Single word:
  - Stimulus: din = 64'h0123_4567_89AB_CDEF offered for one cycle, dout_ready = 1.
  - Required response: bytes 01, 23, 45, 67, 89, AB, CD, EF on 8 consecutive cycles; dout_last only on EF; then IDLE with din_ready = 1.
- Back-to-back words:
  - Stimulus: words 64'h1111_1111_1111_1111 then 64'hFEDC_BA98_7654_3210, din_valid held high, dout_ready = 1.
  - Required response: 16 bytes on 16 consecutive cycles; din_ready pulses only on the two acceptance edges; no gap between 11 and FE.
- Backpressure:
  - Stimulus: dout_ready toggling 1,0,0,1,… pseudo-randomly during 64'hA5A5_5A5A_0F0F_F0F0.
  - Required response: dout stays stable whenever stalled; byte sequence is exactly A5,A5,5A,5A,0F,0F,F0,F0.
- Reset mid-word:
  - Stimulus: assert rst low after 3 bytes of 64'h0102_0304_0506_0708, release, then send 64'hCAFE_0000_0000_BEEF.
  - Required response: dout_valid drops immediately on reset; next bytes are CA,FE,00,00,00,00,BE,EF.
- Round trip:
  - Stimulus: dout fed into the byte shift-in packing line for 8 accepted bytes.
  - Required response: the packed 64-bit register equals the original din.
